// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared vanilla-core types for the register-file writeback path.
// The buffered writeback struct is sized for the core's fixed register file geometry.
package regfile_wb_arbiter_pkg;

   function automatic int safe_clog2(input int x);
      return (x <= 1) ? 1 : $clog2(x);
   endfunction

   localparam int vanilla_data_width_gp = 32;
   localparam int vanilla_reg_els_gp    = 32;
   localparam int vanilla_addr_width_gp = safe_clog2(vanilla_reg_els_gp);

   typedef struct packed {
      logic [vanilla_addr_width_gp-1:0] addr;
      logic [vanilla_data_width_gp-1:0] data;
   } regfile_wb_s;

   typedef enum logic {NORMAL, FORCE} wb_arb_state_e;

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small register-based FIFO of regfile writebacks; ready is derived from the
// registered occupancy only, so there is no pop-through when full.
module bsg_fifo_1r1w_small
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int els_p = 4
)(
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        v_i,
   input  regfile_wb_s data_i,
   output logic        ready_o,
   output logic        v_o,
   output regfile_wb_s data_o,
   input  logic        yumi_i
);

   localparam int ptr_width_lp = safe_clog2(els_p);

   regfile_wb_s             mem [els_p];
   logic [ptr_width_lp-1:0] rd_ptr, wr_ptr;
   logic [ptr_width_lp:0]   count;
   logic                    enq, deq;

   assign ready_o = (count != (ptr_width_lp+1)'(els_p));
   assign v_o     = (count != '0);
   assign data_o  = mem[rd_ptr];
   assign enq     = v_i & ready_o;
   assign deq     = yumi_i & v_o;

   // Depth is a power of two, so pointers wrap naturally.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (enq) wr_ptr <= wr_ptr + 1'b1;
         if (deq) rd_ptr <= rd_ptr + 1'b1;
         case ({enq, deq})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (enq) mem[wr_ptr] <= data_i;
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Sole driver of the integer register file write port: merges in-order pipeline
// writebacks with buffered remote-load responses, stalling the pipe if a response starves.
module regfile_wb_arbiter
   import regfile_wb_arbiter_pkg::*;
#(
   parameter  int data_width_p   = 32,
   parameter  int reg_els_p      = 32,
   parameter  int fifo_els_p     = 4,
   parameter  int starve_limit_p = 8,
   localparam int addr_width_lp  = safe_clog2(reg_els_p)
)(
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     pipe_v_i,
   input  logic [addr_width_lp-1:0] pipe_addr_i,
   input  logic [data_width_p-1:0]  pipe_data_i,
   input  logic                     resp_v_i,
   input  logic [addr_width_lp-1:0] resp_addr_i,
   input  logic [data_width_p-1:0]  resp_data_i,
   output logic                     resp_ready_o,
   output logic                     stall_o,
   output logic                     w_v_o,
   output logic [addr_width_lp-1:0] w_addr_o,
   output logic [data_width_p-1:0]  w_data_o,
   output logic                     clear_v_o,
   output logic [addr_width_lp-1:0] clear_addr_o
);

   localparam int cnt_width_lp = safe_clog2(starve_limit_p) + 1;

   regfile_wb_s               resp_in, head;
   logic                      head_v, pop;
   wb_arb_state_e             state, state_n;
   logic [cnt_width_lp-1:0]   starve_cnt, starve_cnt_n;
   logic                      win_v;
   logic [addr_width_lp-1:0]  win_addr;
   logic [data_width_p-1:0]   win_data;

   assign resp_in = '{addr: resp_addr_i, data: resp_data_i};

   bsg_fifo_1r1w_small #(.els_p(fifo_els_p)) resp_fifo (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .v_i     (resp_v_i),
      .data_i  (resp_in),
      .ready_o (resp_ready_o),
      .v_o     (head_v),
      .data_o  (head),
      .yumi_i  (pop)
   );

   assign stall_o = (state == FORCE);

   always_comb begin
      state_n      = state;
      starve_cnt_n = starve_cnt;
      pop          = 1'b0;
      win_v        = pipe_v_i;
      win_addr     = pipe_addr_i;
      win_data     = pipe_data_i;

      // In FORCE the head wins even against an (illegal) pipeline write.
      if (head_v && (stall_o || !pipe_v_i)) begin
         pop      = 1'b1;
         win_v    = 1'b1;
         win_addr = head.addr;
         win_data = head.data;
      end

      case (state)
         NORMAL: begin
            if (pop) begin
               starve_cnt_n = '0;
            end else if (head_v) begin
               starve_cnt_n = starve_cnt + 1'b1;
               if (starve_cnt == cnt_width_lp'(starve_limit_p - 1)) state_n = FORCE;
            end
         end
         FORCE: begin
            state_n      = NORMAL;
            starve_cnt_n = '0;
         end
         default: state_n = NORMAL;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state      <= NORMAL;
         starve_cnt <= '0;
         w_v_o      <= 1'b0;
         clear_v_o  <= 1'b0;
      end else begin
         state      <= state_n;
         starve_cnt <= starve_cnt_n;
         w_v_o      <= win_v & (win_addr != '0);
         clear_v_o  <= pop;
      end
   end

   always_ff @(posedge clk_i) begin
      w_addr_o     <= win_addr;
      w_data_o     <= win_data;
      clear_addr_o <= head.addr;
   end

   no_pipe_write_during_stall: assert property (
      @(posedge clk_i) disable iff (reset_i) !(stall_o && pipe_v_i));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, hand-written starvation/reset
// sequences and randomized traffic against a queue-based reference model.
module tb_regfile_wb_arbiter;

   localparam int FE = 4;
   localparam int SL = 8;

   logic        clk = 1'b0;
   logic        reset_i = 1'b1;
   logic        pipe_v_i = 1'b0;
   logic [4:0]  pipe_addr_i = '0;
   logic [31:0] pipe_data_i = '0;
   logic        resp_v_i = 1'b0;
   logic [4:0]  resp_addr_i = '0;
   logic [31:0] resp_data_i = '0;
   logic        resp_ready_o, stall_o, w_v_o, clear_v_o;
   logic [4:0]  w_addr_o, clear_addr_o;
   logic [31:0] w_data_o;

   always #5 clk = ~clk;

   regfile_wb_arbiter #(
      .data_width_p(32), .reg_els_p(32), .fifo_els_p(FE), .starve_limit_p(SL)
   ) dut (
      .clk_i(clk), .reset_i(reset_i),
      .pipe_v_i(pipe_v_i), .pipe_addr_i(pipe_addr_i), .pipe_data_i(pipe_data_i),
      .resp_v_i(resp_v_i), .resp_addr_i(resp_addr_i), .resp_data_i(resp_data_i),
      .resp_ready_o(resp_ready_o), .stall_o(stall_o),
      .w_v_o(w_v_o), .w_addr_o(w_addr_o), .w_data_o(w_data_o),
      .clear_v_o(clear_v_o), .clear_addr_o(clear_addr_o)
   );

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic drive(input bit pv, input bit [4:0] pa, input bit [31:0] pd,
                        input bit rv, input bit [4:0] ra, input bit [31:0] rd);
      pipe_v_i    = pv;
      pipe_addr_i = pa;
      pipe_data_i = pd;
      resp_v_i    = rv;
      resp_addr_i = ra;
      resp_data_i = rd;
   endtask

   // Reference model: a queue of pending responses plus a count of lost arbitrations.
   typedef struct packed { bit [4:0] a; bit [31:0] d; } ent_t;
   ent_t q[$];
   int   lose = 0;
   bit   frc = 1'b0;
   bit        m_rdy, m_stall, m_wv, m_cv;
   bit [4:0]  m_wa, m_ca;
   bit [31:0] m_wd;

   function automatic void model_reset();
      q.delete();
      lose = 0;
      frc  = 1'b0;
   endfunction

   function automatic void model_step();
      bit   pop;
      ent_t h;
      m_rdy   = (q.size() < FE);
      m_stall = frc;
      pop     = (q.size() > 0) && (frc || !pipe_v_i);
      m_cv = pop; m_wv = 1'b0; m_wa = '0; m_wd = '0; m_ca = '0;
      if (pop) begin
         h    = q.pop_front();
         m_wv = (h.a != 0);
         m_wa = h.a;
         m_wd = h.d;
         m_ca = h.a;
         lose = 0;
         frc  = 1'b0;
      end else begin
         if (pipe_v_i) begin
            m_wv = (pipe_addr_i != 0);
            m_wa = pipe_addr_i;
            m_wd = pipe_data_i;
         end
         if (q.size() > 0) begin
            lose++;
            if (lose == SL) frc = 1'b1;
         end
      end
      if (resp_v_i && m_rdy) q.push_back('{a: resp_addr_i, d: resp_data_i});
   endfunction

   task automatic mcyc(input string nm, input bit pv, input bit [4:0] pa, input bit [31:0] pd,
                       input bit rv, input bit [4:0] ra, input bit [31:0] rd);
      drive(pv, pa, pd, rv, ra, rd);
      model_step();
      chk({nm, "_rdy"}, 32'(resp_ready_o), 32'(m_rdy));
      chk({nm, "_stall"}, 32'(stall_o), 32'(m_stall));
      tick();
      chk({nm, "_wv"}, 32'(w_v_o), 32'(m_wv));
      if (m_wv) begin
         chk({nm, "_waddr"}, 32'(w_addr_o), 32'(m_wa));
         chk({nm, "_wdata"}, w_data_o, m_wd);
      end
      chk({nm, "_cv"}, 32'(clear_v_o), 32'(m_cv));
      if (m_cv) chk({nm, "_caddr"}, 32'(clear_addr_o), 32'(m_ca));
   endtask

   typedef struct {
      bit [31:0] pv, pa, pd, rv, ra, rd;
      bit [31:0] e_rdy, e_stall, e_wv, e_wa, e_wd, e_cv, e_ca;
   } vec_t;
   vec_t tv[10];

   initial begin
      tv[0] = '{1, 5, 32'hDEADBEEF, 0, 0, 0,           1, 0, 1, 5, 32'hDEADBEEF, 0, 0};
      tv[1] = '{1, 6, 32'h1234,     0, 0, 0,           1, 0, 1, 6, 32'h1234,     0, 0};
      tv[2] = '{0, 0, 0,            1, 10, 32'h55,     1, 0, 0, 0, 0,            0, 0};
      tv[3] = '{0, 0, 0,            0, 0, 0,           1, 0, 1, 10, 32'h55,      1, 10};
      tv[4] = '{0, 0, 0,            0, 0, 0,           1, 0, 0, 0, 0,            0, 0};
      tv[5] = '{1, 0, 32'h7,        0, 0, 0,           1, 0, 0, 0, 0,            0, 0};
      tv[6] = '{0, 0, 0,            1, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 0,           0, 0};
      tv[7] = '{0, 0, 0,            0, 0, 0,           1, 0, 0, 0, 0,            1, 0};
      tv[8] = '{1, 3, 32'hAA,       1, 4, 32'hBB,      1, 0, 1, 3, 32'hAA,       0, 0};
      tv[9] = '{0, 0, 0,            0, 0, 0,           1, 0, 1, 4, 32'hBB,       1, 4};

      tick();
      tick();
      chk("reset_wv", 32'(w_v_o), 0);
      chk("reset_cv", 32'(clear_v_o), 0);
      chk("reset_stall", 32'(stall_o), 0);
      chk("reset_rdy", 32'(resp_ready_o), 1);
      reset_i = 1'b0;
      model_reset();

      // Directed table: pipeline path, single response latency, x0 handling.
      for (int i = 0; i < 10; i++) begin
         drive(tv[i].pv[0], tv[i].pa[4:0], tv[i].pd, tv[i].rv[0], tv[i].ra[4:0], tv[i].rd);
         model_step();
         chk("vec_rdy", 32'(resp_ready_o), tv[i].e_rdy);
         chk("vec_stall", 32'(stall_o), tv[i].e_stall);
         tick();
         chk("vec_wv", 32'(w_v_o), tv[i].e_wv);
         if (tv[i].e_wv[0]) begin
            chk("vec_waddr", 32'(w_addr_o), tv[i].e_wa);
            chk("vec_wdata", w_data_o, tv[i].e_wd);
         end
         chk("vec_cv", 32'(clear_v_o), tv[i].e_cv);
         if (tv[i].e_cv[0]) chk("vec_caddr", 32'(clear_addr_o), tv[i].e_ca);
      end

      // Fill the FIFO under continuous pipeline traffic until the head starves.
      for (int i = 0; i < 9; i++) begin
         if (i == 4) chk("full_rdy", 32'(resp_ready_o), 0);
         if (i == 8) chk("stall_early", 32'(stall_o), 0);
         mcyc("fill", 1'b1, 5'(i + 1), 32'h100 + i, i < 5, 5'(20 + i), 32'hA0 + i);
      end
      chk("stall_rise", 32'(stall_o), 1);
      mcyc("force", 1'b0, 5'd0, 0, 1'b0, 5'd0, 0);
      chk("force_wv", 32'(w_v_o), 1);
      chk("force_waddr", 32'(w_addr_o), 20);
      chk("force_cv", 32'(clear_v_o), 1);
      chk("stall_drop", 32'(stall_o), 0);
      for (int i = 0; i < 4; i++) mcyc("drain", 1'b0, 5'd0, 0, 1'b0, 5'd0, 0);

      // Reset while three responses are buffered and the pipe is stalled.
      for (int i = 0; i < 9; i++)
         mcyc("prerst", 1'b1, 5'd7, 32'(i), i < 3, 5'(9 + i), 32'hC0 + i);
      chk("prerst_stall", 32'(stall_o), 1);
      drive(1'b0, 5'd0, 0, 1'b0, 5'd0, 0);
      reset_i = 1'b1;
      tick();
      model_reset();
      chk("midrst_wv", 32'(w_v_o), 0);
      chk("midrst_cv", 32'(clear_v_o), 0);
      chk("midrst_stall", 32'(stall_o), 0);
      chk("midrst_rdy", 32'(resp_ready_o), 1);
      reset_i = 1'b0;
      for (int i = 0; i < 6; i++) mcyc("postrst", 1'b0, 5'd0, 0, 1'b0, 5'd0, 0);

      // Randomized traffic with varying pipeline pressure.
      for (int i = 0; i < 800; i++) begin
         int prob;
         bit pv;
         case (i / 200)
            0:       prob = 30;
            1:       prob = 95;
            2:       prob = 60;
            default: prob = 100;
         endcase
         pv = !frc && ($urandom_range(99) < prob);
         mcyc("rnd", pv, 5'($urandom_range(31)), $urandom, 1'($urandom_range(1)),
              5'($urandom_range(31)), $urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
